// File: rtl/mem_fifo.sv
// First-word-fall-through synchronous FIFO on a register array with push/pop handshake,
// occupancy count, threshold flags and sticky overflow/underflow.
module mem_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AFULL = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         in,
  input  logic                     pop,
  output logic [WIDTH-1:0]         out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   DepthCnt = DEPTH[AW:0];
  localparam logic [AW:0]   AFullCnt = AFULL[AW:0];
  localparam logic [AW:0]   CntOne   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PtrOne   = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, underflow_q;
  logic             push_ok, pop_ok;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DepthCnt);
  assign almost_full = (count_q >= AFullCnt);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign out         = empty ? '0 : mem[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntOne;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_d;
      if (push && !push_ok) overflow_q <= 1'b1;
      if (pop && empty)     underflow_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset; entries are unreachable until written.
  always_ff @(posedge clock) begin
    if (push_ok && !reset && !clear) begin
      mem[wr_ptr_q] <= in;
    end
  end

endmodule

// File: tb/tb_mem_fifo.sv
// Directed bench for mem_fifo: queue-based reference model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_mem_fifo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFULL = 6;

  logic             clock = 1'b0;
  logic             reset, clear, push, pop;
  logic [WIDTH-1:0] din, dout;
  logic             empty, full, almost_full, overflow, underflow;
  logic [3:0]       count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [WIDTH-1:0] mq[$];
  bit               m_ov, m_un;

  mem_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .push        (push),
    .in          (din),
    .pop         (pop),
    .out         (dout),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO semantics on a queue.
  always @(posedge clock or posedge reset) begin
    if (reset || clear) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      bit was_empty, was_full, pok, qok;
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      pok = push && (!was_full || pop);
      qok = pop && !was_empty;
      if (qok) void'(mq.pop_front());
      if (pok) mq.push_back(din);
      if (push && !pok) m_ov = 1'b1;
      if (pop && was_empty) m_un = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      int n;
      n = mq.size();
      chk("m_count", 32'(count), 32'(n));
      chk("m_empty", 32'(empty), 32'(n == 0));
      chk("m_full", 32'(full), 32'(n == DEPTH));
      chk("m_afull", 32'(almost_full), 32'(n >= AFULL));
      chk("m_out", 32'(dout), (n == 0) ? 32'h0 : 32'(mq[0]));
      chk("m_ovf", 32'(overflow), 32'(m_ov));
      chk("m_unf", 32'(underflow), 32'(m_un));
    end
  end

  // Called at posedge+1: drive for one edge, then return at the next posedge+1.
  task automatic cyc(input bit p, input logic [WIDTH-1:0] d, input bit q, input bit c);
    push = p; din = d; pop = q; clear = c;
    @(posedge clock);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; din = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_out", 32'(dout), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // 1: fill to full
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 16'(i), 1'b0, 1'b0);
      chk("t1_count", 32'(count), 32'(i));
      chk("t1_afull", 32'(almost_full), 32'(i >= 6));
      chk("t1_full", 32'(full), 32'(i == 8));
    end

    // 2: overflow then drain
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("t2_count", 32'(count), 32'd8);
    chk("t2_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_head", 32'(dout), 32'(i));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_out", 32'(dout), 32'd0);

    // 3: push+pop on empty
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t3_clr_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 16'h1234, 1'b1, 1'b0);
    chk("t3_unf", 32'(underflow), 32'd1);
    chk("t3_count", 32'(count), 32'd1);
    chk("t3_out", 32'(dout), 32'h1234);

    // 4: push+pop on full
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    chk("t4_head0", 32'(dout), 32'h0001);
    cyc(1'b1, 16'h00AA, 1'b1, 1'b0);
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_head1", 32'(dout), 32'h0002);
    for (int i = 2; i <= 8; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t4_last", 32'(dout), 32'h00AA);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t4_empty", 32'(empty), 32'd1);

    // 5: wrap-around
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int r = 0; r < 20; r++) begin
      cyc(1'b1, 16'(16'h100 + 2 * r), 1'b0, 1'b0);
      cyc(1'b1, 16'(16'h101 + 2 * r), 1'b0, 1'b0);
      chk("t5_count", 32'(count), 32'd2);
      chk("t5_pop0", 32'(dout), 32'(16'h100 + 2 * r));
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t5_pop1", 32'(dout), 32'(16'h101 + 2 * r));
      cyc(1'b0, '0, 1'b1, 1'b0);
    end

    // 6: async reset mid-cycle, then synchronous clear
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h50 + i), 1'b0, 1'b0);
    chk("t6_pre", 32'(count), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_afull", 32'(almost_full), 32'd0);
    chk("t6_out", 32'(dout), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h70 + i), 1'b0, 1'b0);
    chk("t6_c3", 32'(count), 32'd3);
    cyc(1'b1, 16'h7777, 1'b1, 1'b1);
    chk("t6_clr", 32'(count), 32'd0);
    chk("t6_clr_out", 32'(dout), 32'd0);
    @(posedge clock);
    #1;
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
